disk_ii_rw_ctrl: RTL and testbench

Parametrised Disk II floppy controller core supporting several drives, read and write of nibblized track data, write-protect sense and per-drive dirty tracking. Sits between the 6502 I/O decode (C0Xn soft switches) and an external synchronous dual-port track RAM, which the host loader fills and flushes. Byte timing is derived from a CPU-cycle enable, so the whole block runs in the single `clk` domain.

---
 rtl/disk_ii_rw_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_disk_ii_rw_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disk_ii_rw_ctrl.sv
// disk_ii_rw_ctrl
//   Disk II floppy controller core. It decodes the C0Xn soft switches,
//   steps the head from the four stepper magnets, and times nibbles from the
//   CPU-cycle enable. It also reads and writes nibbles through an external
//   synchronous track RAM and keeps a per-drive dirty flag for the host
//   loader. The whole block runs in the single clk domain.
//
// Ports
//   clk, RESET        clock, asynchronous active-high reset
//   cpu_en            one-clk strobe per 6502 cycle
//   io_on, io_we      CPU access to C0Xn of this slot, write qualifier
//   A, D_IN           low address bits and write data of the access
//   D_OUT             registered CPU read data
//   write_protect     per-drive write-protect sense
//   trk_rd_data       track RAM read data (valid the clk after trk_addr)
//   trk_addr          track RAM address (shared by all drives)
//   trk_wr_data       track RAM write data
//   trk_we            track RAM write strobe (one clk per written nibble)
//   motor_on          drive motor latch
//   drive_sel         selected drive index
//   TRACK             whole-track head position (half-track >> 1)
//   dirty, dirty_clr  per-drive written flag and host clear
module disk_ii_rw_ctrl #(
    parameter int NUM_DRIVES    = 2,
    parameter int TRACK_BYTES   = 6656,
    parameter int ADDR_W        = 13,
    parameter int MAX_HALFTRACK = 139,
    parameter int BYTE_CYCLES   = 32,
    parameter int START_ADDR    = 0
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  cpu_en,
    input  logic                  io_on,
    input  logic                  io_we,
    input  logic [3:0]            A,
    input  logic [7:0]            D_IN,
    output logic [7:0]            D_OUT,
    input  logic [NUM_DRIVES-1:0] write_protect,
    input  logic [7:0]            trk_rd_data,
    output logic [ADDR_W-1:0]     trk_addr,
    output logic [7:0]            trk_wr_data,
    output logic                  trk_we,
    output logic                  motor_on,
    output logic [1:0]            drive_sel,
    output logic [5:0]            TRACK,
    output logic [NUM_DRIVES-1:0] dirty,
    input  logic [NUM_DRIVES-1:0] dirty_clr
);

    localparam int TW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;

    logic [3:0]            mag_q, mag_d;
    logic                  motor_q, motor_d;
    logic [1:0]            sel_q, sel_d;
    logic                  q6_q, q6_d, q7_q, q7_d;
    logic [7:0]            h_q, h_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  adv_q, adv_d;
    logic [7:0]            rd_latch_q, rd_latch_d;
    logic [7:0]            wr_latch_q, wr_latch_d;
    logic [7:0]            dout_q, dout_d;
    logic                  we_q, we_d;
    logic [NUM_DRIVES-1:0] dirty_q, dirty_d;

    logic       wp_sel, adv, rd_cpu;
    logic [1:0] m, mp, mm;
    logic [2:0] step;
    logic [9:0] hn;

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    always_comb begin
        mag_d      = mag_q;
        motor_d    = motor_q;
        sel_d      = sel_q;
        q6_d       = q6_q;
        q7_d       = q7_q;
        h_d        = h_q;
        timer_d    = timer_q;
        addr_d     = addr_q;
        rd_latch_d = rd_latch_q;
        wr_latch_d = wr_latch_q;
        dout_d     = dout_q;
        step       = 3'd0;

        wp_sel = 1'b0;
        for (int i = 0; i < NUM_DRIVES; i++)
            if (sel_q == 2'(i)) wp_sel = write_protect[i];

        // Soft switches: the low address bit is the value, the rest selects the latch.
        if (io_on) begin
            if (!A[3]) mag_d[A[2:1]] = A[0];
            else begin
                case (A[2:1])
                    2'd0:    motor_d = A[0];
                    2'd1:    sel_d   = {1'b0, A[0]};
                    2'd2:    q6_d    = A[0];
                    default: q7_d    = A[0];
                endcase
            end
        end

        // Stepper: the head is pulled toward the magnet pattern that holds a
        // neighbouring half-track. Even positions sit under one magnet, odd
        // ones between two, and both use the magnet index h[2:1].
        m  = h_q[2:1];
        mp = m + 2'd1;
        mm = m - 2'd1;
        if (!h_q[0]) begin
            if      (mag_q == oh(mp))          step = 3'b010;
            else if (mag_q == (oh(m) | oh(mp))) step = 3'b001;
            else if (mag_q == oh(mm))          step = 3'b110;
            else if (mag_q == (oh(mm) | oh(m))) step = 3'b111;
        end else begin
            if      (mag_q[mp] && !mag_q[m]) step = 3'b001;
            else if (mag_q[m] && !mag_q[mp]) step = 3'b111;
        end
        hn = {2'b00, h_q} + {{7{step[2]}}, step};
        if (cpu_en) begin
            if (hn[9])                          h_d = 8'd0;
            else if (hn > 10'(MAX_HALFTRACK))   h_d = 8'(MAX_HALFTRACK);
            else                                h_d = hn[7:0];
        end

        // Nibble timer; with the motor off timer and address just hold.
        adv = motor_q && cpu_en && (timer_q == TW'(BYTE_CYCLES - 1));
        if (motor_q && cpu_en) timer_d = adv ? '0 : timer_q + 1'b1;
        if (adv) addr_d = (addr_q == ADDR_W'(TRACK_BYTES - 1)) ? '0 : addr_q + 1'b1;
        adv_d = adv;

        // The write lands on the new address during the clk after the advance.
        we_d = adv && q7_q && !wp_sel;

        // A fresh nibble from RAM wins over the consume-clear of bit 7.
        rd_cpu = io_on && !io_we && (A == 4'hC) && !q7_q;
        if (adv_q)       rd_latch_d    = trk_rd_data;
        else if (rd_cpu) rd_latch_d[7] = 1'b0;

        // Sense mode is judged on the q6/q7 values this access leaves behind.
        if (io_on && !io_we) begin
            if (rd_cpu)              dout_d = rd_latch_q;
            else if (q6_d && !q7_d)  dout_d = {wp_sel, 7'b0};
            else                     dout_d = 8'h00;
        end

        if (io_on && io_we && (A == 4'hD) && q7_q) wr_latch_d = D_IN;

        // A set on the same clk as a host clear wins.
        dirty_d = dirty_q & ~dirty_clr;
        for (int i = 0; i < NUM_DRIVES; i++)
            if (we_d && (sel_q == 2'(i))) dirty_d[i] = 1'b1;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            mag_q      <= '0;
            motor_q    <= 1'b0;
            sel_q      <= '0;
            q6_q       <= 1'b0;
            q7_q       <= 1'b0;
            h_q        <= '0;
            timer_q    <= '0;
            addr_q     <= ADDR_W'(START_ADDR);
            adv_q      <= 1'b0;
            rd_latch_q <= '0;
            wr_latch_q <= '0;
            dout_q     <= '0;
            we_q       <= 1'b0;
            dirty_q    <= '0;
        end else begin
            mag_q      <= mag_d;
            motor_q    <= motor_d;
            sel_q      <= sel_d;
            q6_q       <= q6_d;
            q7_q       <= q7_d;
            h_q        <= h_d;
            timer_q    <= timer_d;
            addr_q     <= addr_d;
            adv_q      <= adv_d;
            rd_latch_q <= rd_latch_d;
            wr_latch_q <= wr_latch_d;
            dout_q     <= dout_d;
            we_q       <= we_d;
            dirty_q    <= dirty_d;
        end
    end

    assign D_OUT       = dout_q;
    assign trk_addr    = addr_q;
    assign trk_wr_data = wr_latch_q;
    assign trk_we      = we_q;
    assign motor_on    = motor_q;
    assign drive_sel   = sel_q;
    assign TRACK       = h_q[6:1];
    assign dirty       = dirty_q;

endmodule

// File: tb/tb_disk_ii_rw_ctrl.sv
// Bench for disk_ii_rw_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the controller.
module tb_disk_ii_rw_ctrl;
    localparam int NDR = 2, TBY = 40, AW = 7, MAXH = 139, BC = 32, START = 0;

    logic           clk = 0, RESET = 1, cpu_en = 0, io_on = 0, io_we = 0;
    logic [3:0]     A = 0;
    logic [7:0]     D_IN = 0, D_OUT, trk_rd_data = 0, trk_wr_data;
    logic [NDR-1:0] write_protect = '0, dirty, dirty_clr = '0;
    logic [AW-1:0]  trk_addr;
    logic           trk_we, motor_on;
    logic [1:0]     drive_sel;
    logic [5:0]     TRACK;

    always #5 clk = ~clk;

    disk_ii_rw_ctrl #(.NUM_DRIVES(NDR), .TRACK_BYTES(TBY), .ADDR_W(AW),
        .MAX_HALFTRACK(MAXH), .BYTE_CYCLES(BC), .START_ADDR(START)) dut (
        .clk(clk), .RESET(RESET), .cpu_en(cpu_en), .io_on(io_on), .io_we(io_we),
        .A(A), .D_IN(D_IN), .D_OUT(D_OUT), .write_protect(write_protect),
        .trk_rd_data(trk_rd_data), .trk_addr(trk_addr), .trk_wr_data(trk_wr_data),
        .trk_we(trk_we), .motor_on(motor_on), .drive_sel(drive_sel), .TRACK(TRACK),
        .dirty(dirty), .dirty_clr(dirty_clr));

    // Track RAM: data for the address presented after an edge is ready by the next edge.
    logic [7:0] ram [0:(1<<AW)-1];
    always @(negedge clk) trk_rd_data <= ram[trk_addr];
    always @(posedge clk) if (trk_we) ram[trk_addr] <= trk_wr_data;

    int checks = 0, fails = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0]     m_mag;
    bit             m_motor, m_q6, m_q7, m_ld, m_we;
    logic [1:0]     m_sel;
    int             m_h;
    longint         m_ticks;          // cpu_en cycles seen with the motor on
    logic [7:0]     m_rd, m_wr, m_dout;
    logic [NDR-1:0] m_dirty;
    logic [7:0]     m_mem [0:(1<<AW)-1];

    function automatic int m_addr();
        return (START + int'(m_ticks / BC)) % TBY;
    endfunction

    // Magnet that holds an even half-track position.
    function automatic int mag_of(int p);
        return ((p + 16) / 2) % 4;
    endfunction

    // Magnet pattern that holds position p (one magnet even, two magnets odd).
    function automatic logic [3:0] hold(int p);
        if (p % 2 == 0) return 4'(1 << mag_of(p));
        return 4'((1 << mag_of(p - 1)) | (1 << mag_of(p + 1)));
    endfunction

    function automatic int head_next(int h, logic [3:0] mag);
        int n = h;
        bit up, dn;
        if (h % 2 == 0) begin
            if      (mag == hold(h + 2)) n = h + 2;
            else if (mag == hold(h + 1)) n = h + 1;
            else if (mag == hold(h - 2)) n = h - 2;
            else if (mag == hold(h - 1)) n = h - 1;
        end else begin
            up = mag[mag_of(h + 1)];
            dn = mag[mag_of(h - 1)];
            if (up && !dn) n = h + 1;
            else if (dn && !up) n = h - 1;
        end
        if (n < 0) n = 0;
        if (n > MAXH) n = MAXH;
        return n;
    endfunction

    task automatic model_reset();
        m_mag = 0; m_motor = 0; m_q6 = 0; m_q7 = 0; m_ld = 0; m_we = 0;
        m_sel = 0; m_h = 0; m_ticks = 0; m_rd = 0; m_wr = 0; m_dout = 0; m_dirty = 0;
    endtask

    task automatic model_step();
        logic [7:0] mem_rd;
        bit wp, adv, rd_cpu, we;
        int a;
        if (RESET) begin model_reset(); return; end
        a = m_addr();
        mem_rd = m_mem[a];
        if (m_we) m_mem[a] = m_wr;
        wp = (m_sel < NDR) ? write_protect[m_sel] : 1'b0;
        adv = m_motor && cpu_en && (m_ticks % BC == BC - 1);
        rd_cpu = io_on && !io_we && A == 4'hC && !m_q7;
        we = adv && m_q7 && !wp;
        if (io_on && !io_we && rd_cpu) m_dout = m_rd;
        if (m_ld) m_rd = mem_rd; else if (rd_cpu) m_rd[7] = 1'b0;
        if (io_on && io_we && A == 4'hD && m_q7) m_wr = D_IN;
        m_dirty = m_dirty & ~dirty_clr;
        if (we) m_dirty[m_sel] = 1'b1;
        if (cpu_en) m_h = head_next(m_h, m_mag);
        if (m_motor && cpu_en) m_ticks++;
        m_we = we;
        m_ld = adv;
        if (io_on) begin
            if (A < 8) m_mag[A[2:1]] = A[0];
            else if (A < 10) m_motor = A[0];
            else if (A < 12) m_sel = {1'b0, A[0]};
            else if (A < 14) m_q6 = A[0];
            else m_q7 = A[0];
        end
        if (io_on && !io_we && !rd_cpu) m_dout = (m_q6 && !m_q7) ? {wp, 7'b0} : 8'h00;
    endtask

    // ---------------- per-cycle comparison ----------------
    int wraps = 0, wcnt = 0, prev_addr = START;
    bit prev_we = 0;

    task automatic cmp_all();
        chk("addr", trk_addr, m_addr());
        chk("we", trk_we, m_we);
        if (m_we) chk("wdata", trk_wr_data, m_wr);
        chk("dout", D_OUT, m_dout);
        chk("track", TRACK, m_h / 2);
        chk("motor", motor_on, m_motor);
        chk("sel", drive_sel, m_sel);
        chk("dirty", dirty, m_dirty);
        chk("we_back2back", trk_we && prev_we, 0);
        if (prev_addr == TBY - 1 && trk_addr == 0) wraps++;
        if (trk_we) wcnt++;
        prev_addr = trk_addr;
        prev_we = trk_we;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic sw(input logic [3:0] a, input bit we = 0, input logic [7:0] d = 0);
        io_on = 1; io_we = we; A = a; D_IN = d;
        cycle();
        io_on = 0; io_we = 0;
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            cpu_en = 1; cycle();
            cpu_en = 0; cycle();
        end
    endtask

    initial begin
        int up_seq [4];
        int dn_seq [4];
        bit got;
        up_seq = '{1, 2, 3, 0};
        dn_seq = '{3, 2, 1, 0};
        for (int i = 0; i < (1 << AW); i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            ram[i] <= v;
            m_mem[i] = v;
        end
        model_reset();
        repeat (3) cycle();
        chk("rst_addr", trk_addr, START);
        chk("rst_we", trk_we, 0);
        chk("rst_dout", D_OUT, 0);
        chk("rst_motor", motor_on, 0);
        chk("rst_sel", drive_sel, 0);
        chk("rst_track", TRACK, 0);
        chk("rst_dirty", dirty, 0);
        RESET = 0;

        // One full revolution wraps the address exactly once.
        sw(4'h9);
        wraps = 0;
        pulse(BC * TBY);
        chk("wraps", wraps, 1);
        chk("wrap_addr", trk_addr, START);
        sw(4'h8);
        pulse(BC + 3);
        chk("frozen_addr", trk_addr, START);

        // Read a preloaded nibble, then see it consumed.
        ram[5] <= 8'hD5;
        m_mem[5] = 8'hD5;
        sw(4'h9);
        for (int i = 0; i < 400 && trk_addr != 5; i++) pulse(1);
        chk("reach5", trk_addr, 5);
        cycle();
        sw(4'hC); chk("rd_first", D_OUT, 8'hD5);
        sw(4'hC); chk("rd_second", D_OUT, 8'h55);

        // Write-protect sense.
        write_protect = 2'b01;
        sw(4'hD); chk("wp_sense0", D_OUT, 8'h80);
        sw(4'hB); sw(4'hD); chk("wp_sense1", D_OUT, 8'h00);
        sw(4'hA);

        // Stepping out to track 4 and back, then clamp at 0.
        sw(4'h8);
        for (int k = 0; k < 4; k++) begin
            sw(4'(2 * up_seq[k] + 1)); pulse(2); sw(4'(2 * up_seq[k]));
        end
        chk("step_out", TRACK, 4);
        for (int k = 0; k < 4; k++) begin
            sw(4'(2 * dn_seq[k] + 1)); pulse(2); sw(4'(2 * dn_seq[k]));
        end
        chk("step_back", TRACK, 0);
        sw(4'h7); pulse(2); sw(4'h6);
        chk("clamp0", TRACK, 0);

        // Writing with and without write-protect.
        write_protect = 2'b00;
        sw(4'h9); sw(4'hF); sw(4'hD, 1, 8'hFF);
        wcnt = 0;
        pulse(3 * BC);
        chk("we_count", wcnt, 3);
        chk("dirty_set", dirty, 2'b01);
        dirty_clr = 2'b01; cycle(); dirty_clr = 2'b00;
        chk("dirty_clr", dirty, 2'b00);
        write_protect = 2'b01;
        wcnt = 0;
        pulse(2 * BC);
        chk("wp_we_count", wcnt, 0);
        chk("wp_dirty", dirty, 2'b00);

        // Host clear on the same edge that sets dirty loses.
        write_protect = 2'b00;
        for (int i = 0; i < 200 && !(m_motor && (m_ticks % BC == BC - 1)); i++) pulse(1);
        cpu_en = 1; dirty_clr = 2'b01; cycle(); cpu_en = 0; dirty_clr = 2'b00;
        chk("coll_we", trk_we, 1);
        chk("coll_dirty", dirty, 2'b01);
        dirty_clr = 2'b01; cycle(); dirty_clr = 2'b00;
        chk("clr_alone", dirty, 2'b00);

        // Asynchronous reset in the middle of a write pulse.
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            cpu_en = 1; cycle(); cpu_en = 0; got = trk_we;
        end
        chk("pre_rst_we", trk_we, 1);
        RESET = 1;
        #1;
        chk("arst_we", trk_we, 0);
        chk("arst_addr", trk_addr, START);
        chk("arst_dirty", dirty, 0);
        chk("arst_motor", motor_on, 0);
        chk("arst_dout", D_OUT, 0);
        chk("arst_sel", drive_sel, 0);
        model_reset();
        repeat (2) cycle();
        RESET = 0;

        // Random traffic against the model.
        sw(4'h9);
        for (int n = 0; n < 4000; n++) begin
            cpu_en = 1'($urandom_range(0, 1));
            io_on = ($urandom_range(0, 9) == 0);
            io_we = 1'($urandom_range(0, 1));
            A = 4'($urandom_range(0, 15));
            if (A == 4'h8 && $urandom_range(0, 3) != 0) A = 4'h9;
            D_IN = 8'($urandom);
            dirty_clr = ($urandom_range(0, 19) == 0) ? NDR'($urandom) : '0;
            if ($urandom_range(0, 63) == 0) write_protect = NDR'($urandom);
            cycle();
        end
        io_on = 0; cpu_en = 0; dirty_clr = 0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
